// File: rtl/axi_wr_burst_master.sv
// rtl/axi_wr_burst_master.sv - AXI4 write-burst master draining a FWFT FIFO into one AW/W/B transaction
module axi_wr_burst_master #(
  parameter int         AXI_ADDR_W = 30,
  parameter int         AXI_DATA_W = 64,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                    clk,
  input  logic                    rst,
  // burst command from address generation
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [AXI_ADDR_W-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  // first-word-fall-through write FIFO
  input  logic                    fifo_empty,
  input  logic [AXI_DATA_W-1:0]   fifo_rd_data,
  output logic                    fifo_rd_en,
  // status
  output logic                    busy,
  output logic                    done,
  output logic                    resp_err,
  output logic                    bad_4k,
  // AXI write address channel
  output logic [3:0]              m_axi_awid,
  output logic [AXI_ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  // AXI write data channel
  output logic [AXI_DATA_W-1:0]   m_axi_wdata,
  output logic [AXI_DATA_W/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  // AXI write response channel
  input  logic [3:0]              m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);

  typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W, ST_B} state_t;

  state_t                  state_q;
  logic [AXI_ADDR_W-1:0]   awaddr_q;
  logic [7:0]              awlen_q;
  logic                    awvalid_q;
  logic [7:0]              beat_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    resp_err_q;
  logic                    bad_4k_q;

  logic                    accept;
  logic                    w_hs;
  logic [13:0]             end_off;
  logic                    bad_4k_d;
  logic                    unused_bid;

  // Only one transaction is ever outstanding, so the B id carries no information.
  assign unused_bid = ^m_axi_bid;

  // Ready only in IDLE, and held low in the done cycle so a queued command waits one more cycle.
  assign cmd_ready = (state_q == ST_IDLE) && !rst && !done_q;
  assign accept    = cmd_valid && cmd_ready;

  // Byte offset one past the burst end within its 4 KB page; beats are 8 bytes each.
  assign end_off  = {2'b00, cmd_addr[11:0]} + {3'b000, cmd_len, 3'b000} + 14'd8;
  assign bad_4k_d = accept && (end_off > 14'd4096);

  // W channel follows the FIFO head directly so a stalled beat keeps its data.
  assign m_axi_wvalid = (state_q == ST_W) && !fifo_empty;
  assign m_axi_wdata  = fifo_rd_data;
  assign m_axi_wlast  = (beat_q == awlen_q) && m_axi_wvalid;
  assign w_hs         = m_axi_wvalid && m_axi_wready;
  assign fifo_rd_en   = w_hs;

  assign m_axi_bready = (state_q == ST_B);

  assign m_axi_awid    = AXI_ID;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = 3'd3;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wstrb   = '1;

  assign busy     = busy_q;
  assign done     = done_q;
  assign resp_err = resp_err_q;
  assign bad_4k   = bad_4k_q;

  // Burst sequencer: accept command, issue AW, stream W beats, collect B.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      awaddr_q   <= '0;
      awlen_q    <= '0;
      awvalid_q  <= 1'b0;
      beat_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      resp_err_q <= 1'b0;
      bad_4k_q   <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      resp_err_q <= 1'b0;
      bad_4k_q   <= bad_4k_d;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            awaddr_q  <= cmd_addr;
            awlen_q   <= cmd_len;
            beat_q    <= '0;
            busy_q    <= 1'b1;
            awvalid_q <= 1'b1;
            state_q   <= ST_AW;
          end
        end
        ST_AW: begin
          if (m_axi_awready) begin
            awvalid_q <= 1'b0;
            state_q   <= ST_W;
          end
        end
        ST_W: begin
          if (w_hs) begin
            beat_q <= beat_q + 8'd1;
            if (beat_q == awlen_q) begin
              state_q <= ST_B;
            end
          end
        end
        ST_B: begin
          if (m_axi_bvalid) begin
            done_q     <= 1'b1;
            resp_err_q <= (m_axi_bresp != 2'b00);
            busy_q     <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_burst_master.sv
// tb/tb_axi_wr_burst_master.sv - directed table-driven bench for axi_wr_burst_master
module tb_axi_wr_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [29:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        fifo_empty;
  logic [63:0] fifo_rd_data;
  logic        fifo_rd_en;
  logic        busy, done, resp_err, bad_4k;
  logic [3:0]  awid;
  logic [29:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic [3:0]  awqos;
  logic        awvalid, awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  axi_wr_burst_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .busy(busy), .done(done), .resp_err(resp_err), .bad_4k(bad_4k),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
  );

  always #5 clk = ~clk;

  // FWFT FIFO model: test pushes, monitor pops
  logic [63:0] mem [0:4095];
  int rd_ptr = 0;
  int wr_ptr = 0;
  assign fifo_empty   = (rd_ptr == wr_ptr);
  assign fifo_rd_data = mem[rd_ptr[11:0]];

  int n_pass = 0;
  int n_chk  = 0;

  // slave configuration
  int         aw_delay  = 0;
  bit         w_rand    = 0;
  logic [1:0] bresp_cfg = 2'b00;

  // monitor state
  int cyc = 0, viol = 0;
  int acc_cyc, aw_cyc, awhs_cyc, wfirst_cyc, wend_cyc, b_cyc, done_cyc;
  int nbeats = 0, rd_cnt = 0, bad4k_cnt = 0, err_cnt = 0;
  logic err_at_done;
  logic [29:0] cap_awaddr;
  logic [7:0]  cap_awlen;
  logic [63:0] cap_data [$];
  bit          cap_last [$];
  bit aw_done = 0, b_pend = 0;
  int aw_wait = 0;
  bit p_rst = 1, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_wlast = 0;
  logic [29:0] p_awaddr;
  logic [63:0] p_wdata;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Monitor and slave: sample at negedge, drive slave inputs just after posedge
  initial begin
    bit s_rd, s_awhs, s_whs, s_bhs;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00; bid = 4'd0;
    forever begin
      @(negedge clk);
      cyc++;
      s_rd   = fifo_rd_en;
      s_awhs = awvalid && awready;
      s_whs  = wvalid && wready;
      s_bhs  = bvalid && bready;
      if (rst) begin
        aw_done = 0; b_pend = 0; aw_wait = 0;
      end else begin
        if (!p_rst) begin
          if (p_awv && !p_awr && (!awvalid || awaddr !== p_awaddr)) viol++;
          if (p_wv && !p_wr && (!wvalid || wdata !== p_wdata || wlast !== p_wlast)) viol++;
        end
        if (wvalid && fifo_empty) viol++;
        if (wvalid && !aw_done) viol++;
        if (cmd_ready && (busy || done)) viol++;
        if (bready && !busy) viol++;
        if (cmd_valid && cmd_ready) begin
          acc_cyc = cyc; aw_cyc = -1; awhs_cyc = -1; wfirst_cyc = -1; wend_cyc = -1;
          b_cyc = -1; done_cyc = -1; nbeats = 0; rd_cnt = 0; bad4k_cnt = 0; err_cnt = 0;
          err_at_done = 0; cap_data.delete(); cap_last.delete(); aw_done = 0;
        end
        if (awvalid && aw_cyc < 0) aw_cyc = cyc;
        if (s_awhs) begin
          awhs_cyc = cyc; cap_awaddr = awaddr; cap_awlen = awlen; aw_done = 1; aw_wait = 0;
        end else if (awvalid) aw_wait++;
        if (s_whs) begin
          cap_data.push_back(wdata); cap_last.push_back(wlast); nbeats++;
          if (wfirst_cyc < 0) wfirst_cyc = cyc;
          if (wlast) begin wend_cyc = cyc; b_pend = 1; end
        end
        if (s_rd) rd_cnt++;
        if (s_bhs) begin b_cyc = cyc; b_pend = 0; end
        if (bad_4k) bad4k_cnt++;
        if (resp_err) err_cnt++;
        if (done) begin done_cyc = cyc; err_at_done = resp_err; end
      end
      p_rst = rst; p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
      p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wlast = wlast;
      @(posedge clk); #1;
      if (s_rd) rd_ptr++;
      awready = (aw_wait >= aw_delay);
      wready  = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      bvalid  = b_pend;
      bresp   = bresp_cfg;
    end
  end

  task automatic push(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr[11:0]] = base + 64'(i);
      wr_ptr++;
    end
  endtask

  task automatic issue(input logic [29:0] a, input logic [7:0] l);
    bit ok = 0;
    @(posedge clk); #2;
    cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    check("cmd_accept", ok, 1);
    @(posedge clk); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    check("done_seen", ok, 1);
    @(posedge clk); #2;
  endtask

  task automatic check_burst(input string tag, input logic [29:0] a, input logic [7:0] l,
                             input logic [63:0] base, input bit lat);
    int bad_d = 0, bad_l = 0;
    int n = int'(l) + 1;
    for (int i = 0; i < cap_data.size(); i++) begin
      if (cap_data[i] !== base + 64'(i)) bad_d++;
      if (cap_last[i] != (i == n - 1)) bad_l++;
    end
    check({tag, "_awaddr"}, cap_awaddr, a);
    check({tag, "_awlen"}, cap_awlen, l);
    check({tag, "_beats"}, nbeats, n);
    check({tag, "_data"}, bad_d, 0);
    check({tag, "_wlast"}, bad_l, 0);
    check({tag, "_rd_en"}, rd_cnt, n);
    check({tag, "_done_lat"}, done_cyc - b_cyc, 1);
    check({tag, "_protocol"}, viol, 0);
    if (lat) begin
      check({tag, "_aw_lat"}, aw_cyc - acc_cyc, 1);
      check({tag, "_w0_lat"}, wfirst_cyc - acc_cyc, 2);
      check({tag, "_wn_lat"}, wend_cyc - acc_cyc, 2 + int'(l));
    end
  endtask

  typedef struct {
    logic [29:0] addr;
    logic [7:0]  len;
    logic [1:0]  bresp;
    bit          exp_bad4k;
    bit          exp_err;
  } vec_t;

  vec_t vecs [8];

  initial begin
    bit ok, prev_done;
    int gap_hi;
    vecs[0] = '{30'h100, 8'd15,  2'b00, 1'b0, 1'b0};
    vecs[1] = '{30'h000, 8'd0,   2'b00, 1'b0, 1'b0};
    vecs[2] = '{30'h000, 8'd255, 2'b00, 1'b0, 1'b0};
    vecs[3] = '{30'hF80, 8'd31,  2'b00, 1'b1, 1'b0};
    vecs[4] = '{30'h200, 8'd3,   2'b10, 1'b0, 1'b1};
    vecs[5] = '{30'hFF8, 8'd0,   2'b00, 1'b0, 1'b0};
    vecs[6] = '{30'hFF8, 8'd1,   2'b11, 1'b1, 1'b1};
    vecs[7] = '{30'h808, 8'd255, 2'b01, 1'b1, 1'b1};

    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_wlast", wlast, 0);
    check("rst_bready", bready, 0);
    check("rst_status", {busy, done, resp_err, bad_4k}, 4'b0000);
    check("rst_awaddr", awaddr, 0);
    check("rst_awlen", awlen, 0);
    check("const_aw", {awid, awsize, awburst, awlock, awcache, awprot, awqos},
          {4'd0, 3'd3, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0});
    check("const_wstrb", wstrb, 8'hFF);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", cmd_ready, 1);

    // table-driven bursts against a zero-wait slave with the FIFO preloaded
    for (int k = 0; k < 8; k++) begin
      bresp_cfg = vecs[k].bresp;
      push(int'(vecs[k].len) + 1, 64'(k) << 16);
      issue(vecs[k].addr, vecs[k].len);
      wait_done();
      check_burst($sformatf("v%0d", k), vecs[k].addr, vecs[k].len, 64'(k) << 16, 1);
      check($sformatf("v%0d_bad_4k", k), bad4k_cnt, int'(vecs[k].exp_bad4k));
      check($sformatf("v%0d_resp_err", k), err_at_done, vecs[k].exp_err);
      check($sformatf("v%0d_err_pulses", k), err_cnt, int'(vecs[k].exp_err));
    end
    bresp_cfg = 2'b00;

    // backpressure: awready after 5 cycles, wready random
    aw_delay = 5; w_rand = 1;
    push(16, 64'hB000);
    issue(30'h340, 8'd15);
    wait_done();
    check_burst("bp", 30'h340, 8'd15, 64'hB000, 0);
    check("bp_aw_wait", awhs_cyc - aw_cyc, 5);
    aw_delay = 0; w_rand = 0;

    // FIFO underflow: 4 words, 10-cycle gap, then 4 more
    push(4, 64'hC000);
    issue(30'h400, 8'd7);
    ok = 0;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk); #2;
      if (rd_ptr == wr_ptr) begin ok = 1; break; end
    end
    check("uf_drained", ok, 1);
    gap_hi = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (wvalid) gap_hi++;
    end
    check("uf_gap_wvalid", gap_hi, 0);
    check("uf_beats_in_gap", nbeats, 4);
    @(posedge clk); #2;
    push(4, 64'hC004);
    wait_done();
    check_burst("uf", 30'h400, 8'd7, 64'hC000, 0);

    // second command held during busy is accepted the cycle after done
    push(4, 64'hD000);
    push(4, 64'hE000);
    issue(30'h500, 8'd3);
    cmd_addr = 30'h600; cmd_len = 8'd3; cmd_valid = 1'b1;
    ok = 0; prev_done = 0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
      prev_done = done;
    end
    check("q2_accepted", ok, 1);
    check("q2_after_done", prev_done, 1);
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    wait_done();
    check_burst("q2", 30'h600, 8'd3, 64'hE000, 0);

    // reset at beat 3 of 16
    push(16, 64'hF000);
    issue(30'h700, 8'd15);
    ok = 0;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk); #2;
      if (nbeats >= 3) begin ok = 1; break; end
    end
    check("rb_reached_beat3", ok, 1);
    rst = 1'b1;
    @(posedge clk); #2;
    @(negedge clk);
    check("rb_valids", {awvalid, wvalid, wlast, bready}, 4'b0000);
    check("rb_busy_done", {busy, done}, 2'b00);
    check("rb_cmd_ready", cmd_ready, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    wr_ptr = rd_ptr;
    @(negedge clk);
    check("rb_idle_ready", cmd_ready, 1);
    push(4, 64'hA000);
    issue(30'h7C0, 8'd3);
    wait_done();
    check_burst("rb_next", 30'h7C0, 8'd3, 64'hA000, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
